down_count_monitor: RTL and testbench
=====================================

Name: down_count_monitor

Overview:
- Downstream consumer of the 4-bit synchronous down counter's output bus.
- Samples the count every qualified cycle and checks that it steps down by exactly 1 modulo 16 (0 -> 15 is legal).
- Reports lock state, counts full-period wraps, flags sequence faults.
- Gives the lab top level a self-check of the counter without a logic analyser.

Parameters:
- WRAP_W, 8, width of wrap counter; wraps modulo 2^WRAP_W.
- ERR_W, 4, width of error counter; saturates at all-ones.
- LOCK_N, 2, consecutive correct decrements required to enter LOCKED (legal 1..7).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset; all state cleared while low.
- count_in  input  4  count from the upstream down counter.
- count_valid  input  1  qualifies count_in; when low, the monitor holds all state.
- clear_err  input  1  synchronous; clears the sticky error and leaves FAULT.
- locked  output  1  high in LOCKED state.
- seq_err  output  1  sticky fault flag.
- wrap_pulse  output  1  one-cycle pulse on an observed 0 -> 15 step while LOCKED.
- wrap_count  output  WRAP_W  number of wraps seen while LOCKED.
- err_count  output  ERR_W  number of faults detected, saturating.

Behaviour:
- Reset (rst low, asynchronous): state = ACQUIRE, prev_valid = 0, match run = 0; all outputs 0.
- Internal registers:
  - prev[3:0]: last sampled count.
  - prev_valid: prev holds a real sample.
  - run counter: counts consecutive good steps, 3 bits.
- Expected next value is (prev - 1) mod 16, computed in 4 bits. Only 0 -> 15 wraps.
- Sample event: count_valid high on a clk edge. Without one, nothing changes except wrap_pulse, which deasserts.
- On every sample event: prev <= count_in, prev_valid <= 1.
- "Good step": prev_valid = 1 and count_in == expected.
- ACQUIRE:
  - First sample only loads prev.
  - Each good step increments the run counter.
  - A bad step resets the run to 0 and does not count as an error.
  - When the run reaches LOCK_N, go to LOCKED; locked asserts on that same edge.
- LOCKED:
  - A good step stays in LOCKED.
  - If a good step has prev == 0 and count_in == 15: wrap_pulse = 1 for exactly one cycle, and wrap_count increments. wrap_count wraps at 2^WRAP_W - 1 -> 0.
  - A bad step goes to FAULT: seq_err <= 1, err_count increments (held at max when saturated), locked <= 0.
- FAULT:
  - Holds until clear_err. It still tracks prev on every sample event.
  - No wraps are counted and no further err_count increments occur.
- clear_err:
  - In FAULT: go to ACQUIRE, seq_err <= 0, run <= 0. prev is kept, so reacquire can start immediately on the next sample.
  - In other states: ignored. err_count is never cleared except by reset.
- Simultaneous events:
  - clear_err in the same cycle as a sample in FAULT: clear wins. The state goes to ACQUIRE, prev updates, and the run is not advanced on that cycle.
  - A bad step and a wrap in the same cycle cannot coexist, because a bad step is by definition not a wrap.
- Reset mid-operation: immediate return to reset values. wrap_pulse is forced low asynchronously.
- Latency: all outputs are registered, so they reflect the sample one cycle after the edge on which it is taken.

Optional Feature:
- Macro: DCM_AUTO_RESYNC_EN
- Defined:
  - In FAULT, the monitor performs the ACQUIRE run-count procedure on its own.
  - After LOCK_N consecutive good steps it returns to LOCKED without clear_err.
  - seq_err stays set (sticky) until clear_err. In that case clear_err clears the flag only and does not change state.
- Undefined: FAULT exits only via clear_err, as specified above.

Test Plan:
- Reset, then drive 9, 8, 7 with count_valid = 1 (LOCK_N = 2) -> locked = 1 after the sample of 7; seq_err = 0; wrap_count = 0.
- Free-running counter from 15 for 40 samples after lock -> exactly 2 wrap_pulse cycles, each one cycle after the 0 -> 15 sample; wrap_count = 2; err_count = 0.
- Locked at 5, inject 3 instead of 4 -> the next cycle shows seq_err = 1, locked = 0, err_count = 1. Then inject 2 more bad values -> err_count stays 1.
- In FAULT, pulse clear_err alongside sample 2, then feed 1, 0 -> seq_err = 0 after clear; locked = 1 after the sample of 0 (compiled without DCM_AUTO_RESYNC_EN).
- count_valid toggled low for 5 cycles mid-sequence with count_in garbage -> no state change. Resuming with the correct next value keeps locked = 1.
- Assert rst low asynchronously mid-cycle while wrap_pulse = 1 -> all outputs 0 immediately. With DCM_AUTO_RESYNC_EN defined, FAULT followed by 3 good steps gives locked = 1 with seq_err still 1.

Source files
------------

// File: rtl/down_count_monitor.sv
// Checks that a 4-bit down counter steps by -1 mod 16; reports lock, wraps and faults.
// Latency: all outputs registered, valid one cycle after the sampling edge.
// Backpressure: none; count_valid low freezes all state (wrap_pulse drops).
// Optional build macro DCM_AUTO_RESYNC_EN: FAULT re-acquires lock on its own.
module down_count_monitor #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4,
  parameter int LOCK_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        count_in,
  input  logic              count_valid,
  input  logic              clear_err,
  output logic              locked,
  output logic              seq_err,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKED  = 2'd1,
    FAULT   = 2'd2
  } state_t;

  localparam logic [2:0]        LOCK_V  = 3'(LOCK_N);
  localparam logic [ERR_W-1:0]  ERR_MAX = '1;

  state_t            state, state_n;
  logic [3:0]        prev, prev_n;
  logic              prev_valid, prev_valid_n;
  logic [2:0]        run, run_n;
  logic              seq_err_n;
  logic              wrap_pulse_n;
  logic [WRAP_W-1:0] wrap_count_n;
  logic [ERR_W-1:0]  err_count_n;

  logic [3:0]        expected;
  logic              good;
  logic              is_wrap;
  logic [2:0]        run_inc;

  assign expected = prev - 4'd1;
  assign good     = prev_valid && (count_in == expected);
  assign is_wrap  = (prev == 4'd0) && (count_in == 4'hF);
  assign run_inc  = run + 3'd1;
  assign locked   = (state == LOCKED);

  // State and counter registers; reset returns everything to idle at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACQUIRE;
      prev       <= 4'd0;
      prev_valid <= 1'b0;
      run        <= 3'd0;
      seq_err    <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      prev_valid <= prev_valid_n;
      run        <= run_n;
      seq_err    <= seq_err_n;
      wrap_pulse <= wrap_pulse_n;
      wrap_count <= wrap_count_n;
      err_count  <= err_count_n;
    end
  end

  // Next-state logic: only a sample event moves anything except wrap_pulse.
  always_comb begin
    state_n      = state;
    prev_n       = prev;
    prev_valid_n = prev_valid;
    run_n        = run;
    seq_err_n    = seq_err;
    wrap_pulse_n = 1'b0;
    wrap_count_n = wrap_count;
    err_count_n  = err_count;

    if (count_valid) begin
      prev_n       = count_in;
      prev_valid_n = 1'b1;

`ifdef DCM_AUTO_RESYNC_EN
      // Clear only drops the flag; re-acquisition is automatic.
      if (clear_err) begin
        seq_err_n = 1'b0;
      end
`endif

      case (state)
        ACQUIRE: begin
          if (good) begin
            if (run_inc >= LOCK_V) begin
              state_n = LOCKED;
              run_n   = 3'd0;
            end else begin
              run_n = run_inc;
            end
          end else begin
            run_n = 3'd0;
          end
        end

        LOCKED: begin
          if (good) begin
            if (is_wrap) begin
              wrap_pulse_n = 1'b1;
              wrap_count_n = wrap_count + WRAP_W'(1);
            end
          end else begin
            state_n   = FAULT;
            seq_err_n = 1'b1;
            run_n     = 3'd0;
            if (err_count != ERR_MAX) begin
              err_count_n = err_count + ERR_W'(1);
            end
          end
        end

        FAULT: begin
`ifdef DCM_AUTO_RESYNC_EN
          // Same run-count procedure as ACQUIRE; seq_err stays sticky.
          if (good) begin
            if (run_inc >= LOCK_V) begin
              state_n = LOCKED;
              run_n   = 3'd0;
            end else begin
              run_n = run_inc;
            end
          end else begin
            run_n = 3'd0;
          end
`else
          // Clear wins over any run progress on the same sample; prev still updates.
          if (clear_err) begin
            state_n   = ACQUIRE;
            seq_err_n = 1'b0;
            run_n     = 3'd0;
          end
`endif
        end

        default: begin
          state_n = ACQUIRE;
          run_n   = 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_count_monitor.sv
// Directed bench for down_count_monitor with a queue scoreboard.
// Driver pushes one expected output set per cycle; monitor pops after each edge.
// Works for both builds; expectations branch on DCM_AUTO_RESYNC_EN.
module tb_down_count_monitor;

  logic       clk;
  logic       rst;
  logic [3:0] count_in;
  logic       count_valid;
  logic       clear_err;
  logic       locked;
  logic       seq_err;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic [3:0] err_count;

  typedef struct {
    string      name;
    logic       lk;
    logic       se;
    logic       wp;
    logic [7:0] wc;
    logic [3:0] ec;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  down_count_monitor #(.WRAP_W(8), .ERR_W(4), .LOCK_N(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .count_in    (count_in),
    .count_valid (count_valid),
    .clear_err   (clear_err),
    .locked      (locked),
    .seq_err     (seq_err),
    .wrap_pulse  (wrap_pulse),
    .wrap_count  (wrap_count),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string nm, input logic [3:0] v, input logic vld, input logic clr,
                      input logic lk, input logic se, input logic wp,
                      input logic [7:0] wc, input logic [3:0] ec);
    exp_t e;
    @(negedge clk);
    count_in    = v;
    count_valid = vld;
    clear_err   = clr;
    e.name = nm; e.lk = lk; e.se = se; e.wp = wp; e.wc = wc; e.ec = ec;
    q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (locked !== e.lk || seq_err !== e.se || wrap_pulse !== e.wp ||
            wrap_count !== e.wc || err_count !== e.ec) begin
          n_bad++;
          $display("FAIL %s: got lk=%0b se=%0b wp=%0b wc=%0d ec=%0d, want lk=%0b se=%0b wp=%0b wc=%0d ec=%0d",
                   e.name, locked, seq_err, wrap_pulse, wrap_count, err_count,
                   e.lk, e.se, e.wp, e.wc, e.ec);
        end
      end
    end
  end

  initial begin
    logic [3:0] v;
    logic [3:0] pv;
    logic [7:0] wc;
    logic       wp;

    rst = 1'b0; count_in = 4'd0; count_valid = 1'b0; clear_err = 1'b0;

    // Reset state
    step("reset0", 4'd0, 1'b0, 1'b0, 0, 0, 0, 8'd0, 4'd0);
    step("reset1", 4'd5, 1'b1, 1'b0, 0, 0, 0, 8'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;

    // Acquire: 9, 8, 7 -> locked after the sample of 7
    step("acq9", 4'd9, 1'b1, 1'b0, 0, 0, 0, 8'd0, 4'd0);
    step("acq8", 4'd8, 1'b1, 1'b0, 0, 0, 0, 8'd0, 4'd0);
    step("acq7", 4'd7, 1'b1, 1'b0, 1, 0, 0, 8'd0, 4'd0);

    // Free-running from 6 for 38 samples: two 0 -> 15 steps, ends on 1
    pv = 4'd7;
    wc = 8'd0;
    for (int i = 0; i < 38; i++) begin
      v  = pv - 4'd1;
      wp = (pv == 4'd0) && (v == 4'hF);
      if (wp) wc = wc + 8'd1;
      step("freerun", v, 1'b1, 1'b0, 1, 0, wp, wc, 4'd0);
      pv = v;
    end

    // count_valid low with garbage on count_in: nothing moves
    for (int i = 0; i < 5; i++) begin
      v = 4'(4'hA + i[3:0]);
      step("hold", v, 1'b0, 1'b0, 1, 0, 0, 8'd2, 4'd0);
    end
    step("resume0", 4'd0, 1'b1, 1'b0, 1, 0, 0, 8'd2, 4'd0);
    step("wrap3", 4'hF, 1'b1, 1'b0, 1, 0, 1, 8'd3, 4'd0);
    for (int i = 14; i >= 5; i--) begin
      v = 4'(i);
      step("down", v, 1'b1, 1'b0, 1, 0, 0, 8'd3, 4'd0);
    end

    // Fault: 3 instead of 4, then two more bad values without further counting
    step("fault", 4'd3, 1'b1, 1'b0, 0, 1, 0, 8'd3, 4'd1);
    step("bad_a", 4'd9, 1'b1, 1'b0, 0, 1, 0, 8'd3, 4'd1);
    step("bad_b", 4'd9, 1'b1, 1'b0, 0, 1, 0, 8'd3, 4'd1);

    // Clear alongside sample 2, then 1, 0 -> relocked
    step("clear2", 4'd2, 1'b1, 1'b1, 0, 0, 0, 8'd3, 4'd1);
    step("reacq1", 4'd1, 1'b1, 1'b0, 0, 0, 0, 8'd3, 4'd1);
    step("reacq0", 4'd0, 1'b1, 1'b0, 1, 0, 0, 8'd3, 4'd1);
    step("wrap4",  4'hF, 1'b1, 1'b0, 1, 0, 1, 8'd4, 4'd1);

    // Asynchronous reset mid-cycle while wrap_pulse is high
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (locked !== 1'b0 || seq_err !== 1'b0 || wrap_pulse !== 1'b0 ||
        wrap_count !== 8'd0 || err_count !== 4'd0) begin
      n_bad++;
      $display("FAIL async_rst: got lk=%0b se=%0b wp=%0b wc=%0d ec=%0d, want all 0",
               locked, seq_err, wrap_pulse, wrap_count, err_count);
    end
    step("in_rst", 4'd3, 1'b1, 1'b0, 0, 0, 0, 8'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fault followed by good steps: relocks only with auto resync
    step("r_acq9", 4'd9, 1'b1, 1'b0, 0, 0, 0, 8'd0, 4'd0);
    step("r_acq8", 4'd8, 1'b1, 1'b0, 0, 0, 0, 8'd0, 4'd0);
    step("r_acq7", 4'd7, 1'b1, 1'b0, 1, 0, 0, 8'd0, 4'd0);
    step("r_flt3", 4'd3, 1'b1, 1'b0, 0, 1, 0, 8'd0, 4'd1);
    step("r_g2",   4'd2, 1'b1, 1'b0, 0, 1, 0, 8'd0, 4'd1);
`ifdef DCM_AUTO_RESYNC_EN
    step("r_g1",   4'd1, 1'b1, 1'b0, 1, 1, 0, 8'd0, 4'd1);
    step("r_g0",   4'd0, 1'b1, 1'b0, 1, 1, 0, 8'd0, 4'd1);
    step("r_clr",  4'hF, 1'b1, 1'b1, 1, 0, 1, 8'd1, 4'd1);
`else
    step("r_g1",   4'd1, 1'b1, 1'b0, 0, 1, 0, 8'd0, 4'd1);
    step("r_g0",   4'd0, 1'b1, 1'b0, 0, 1, 0, 8'd0, 4'd1);
    step("r_clr",  4'hF, 1'b1, 1'b1, 0, 0, 0, 8'd0, 4'd1);
`endif
    // Clear outside FAULT never touches err_count
    step("r_idle", 4'hE, 1'b0, 1'b1, locked_exp(), 0, 0, wrap_exp(), 4'd1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Build-dependent expectations for the final idle cycle.
  function automatic logic locked_exp();
`ifdef DCM_AUTO_RESYNC_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] wrap_exp();
`ifdef DCM_AUTO_RESYNC_EN
    return 8'd1;
`else
    return 8'd0;
`endif
  endfunction

endmodule
